// File: rtl/spi_fram_responder.sv
// SPI mode-0 target emulating a serial FRAM (WREN/WRDI/RDSR/READ/WRITE)
// backed by an on-chip byte array. All SPI pins are sampled in clk.
module spi_fram_responder #(
    parameter int MEM_AW = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic wel,
    output logic active
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, RDSR, IGNORE
    } state_t;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;

    state_t state, state_nx;

    logic [2:0]  cs_sync, sclk_sync;
    logic [1:0]  mosi_sync;
    logic [1:0]  settle;
    logic        settled;
    logic        cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in, byte_next, tx_shift, load_byte, mem_q, wr_byte;
    logic        byte_done;
    logic [15:0] addr;
    logic        is_read;
    logic        pend_set, pend_clr;
    logic        fetch, wr_pend;

    logic [7:0]  mem [0:(1<<MEM_AW)-1];

    // Synchronize SPI pins; third flop of cs/sclk provides edge detection.
    // cs idles high so a reset with cs high produces no spurious edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            mosi_sync <= '0;
            settle    <= '0;
        end else begin
            cs_sync   <= {cs_sync[1:0], spi_cs};
            sclk_sync <= {sclk_sync[1:0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    // Edges are ignored until the synchronizers have refilled after reset,
    // so a cs held low across reset lands in IGNORE instead of a false CMD.
    assign settled   = (settle == 2'd3);
    assign cs_rise   = settled &  cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = settled & ~cs_sync[1] &  cs_sync[2];
    assign sclk_rise = settled & ~cs_rise &  sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = settled & ~cs_rise & ~sclk_sync[1] &  sclk_sync[2];

    assign byte_next = {shift_in[6:0], mosi_sync[1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign load_byte = (state == RDSR) ? {6'b0, wel, 1'b0} : mem_q;
    assign active    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; a cs rise overrides everything else.
    always_comb begin
        state_nx = state;
        if (cs_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall)
                        state_nx = CMD;
                    else if (settled && !cs_sync[2])
                        state_nx = IGNORE;
                end
                CMD: begin
                    if (byte_done) begin
                        case (byte_next)
                            OP_RDSR:           state_nx = RDSR;
                            OP_READ, OP_WRITE: state_nx = ADDR_HI;
                            default:           state_nx = IGNORE;
                        endcase
                    end
                end
                ADDR_HI: if (byte_done) state_nx = ADDR_LO;
                ADDR_LO: if (byte_done) state_nx = is_read ? RD_DATA : WR_DATA;
                default: state_nx = state;
            endcase
        end
    end

    // Bit framing, address, write-enable latch and MISO shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            shift_in <= '0;
            tx_shift <= '0;
            spi_miso <= 1'b0;
            addr     <= '0;
            is_read  <= 1'b0;
            wel      <= 1'b0;
            pend_set <= 1'b0;
            pend_clr <= 1'b0;
            fetch    <= 1'b0;
            wr_pend  <= 1'b0;
            wr_byte  <= '0;
        end else begin
            fetch   <= 1'b0;
            wr_pend <= 1'b0;
            if (wr_pend) addr <= addr + 16'd1;
            if (cs_rise) begin
                bit_cnt  <= '0;
                shift_in <= '0;
                spi_miso <= 1'b0;
                if (pend_set)      wel <= 1'b1;
                else if (pend_clr) wel <= 1'b0;
                pend_set <= 1'b0;
                pend_clr <= 1'b0;
            end else if (cs_fall && state == IDLE) begin
                bit_cnt  <= '0;
                shift_in <= '0;
                pend_set <= 1'b0;
                pend_clr <= 1'b0;
            end else begin
                if (sclk_rise && state != IDLE) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    shift_in <= byte_next;
                    // Any bit clocked after a WREN/WRDI opcode cancels it.
                    if (state == IGNORE) begin
                        pend_set <= 1'b0;
                        if (!(pend_clr && pend_set == 1'b0 && is_read)) pend_clr <= 1'b0;
                    end
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            CMD: begin
                                is_read <= (byte_next == OP_READ);
                                if (byte_next == OP_WREN) pend_set <= 1'b1;
                                if (byte_next == OP_WRDI) pend_clr <= 1'b1;
                                if (byte_next == OP_WRITE && wel) pend_clr <= 1'b1;
                            end
                            ADDR_HI: addr[15:8] <= byte_next;
                            ADDR_LO: begin
                                addr[7:0] <= byte_next;
                                fetch     <= is_read;
                            end
                            WR_DATA: begin
                                wr_byte <= byte_next;
                                wr_pend <= 1'b1;
                            end
                            RD_DATA: begin
                                addr  <= addr + 16'd1;
                                fetch <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                if (sclk_fall) begin
                    if (state == RD_DATA || state == RDSR) begin
                        if (bit_cnt == 3'd0) begin
                            spi_miso <= load_byte[7];
                            tx_shift <= {load_byte[6:0], 1'b0};
                        end else begin
                            spi_miso <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end else begin
                        spi_miso <= 1'b0;
                    end
                end
            end
        end
    end

    // Single-port byte array: one write or one registered read per cycle.
    always_ff @(posedge clk) begin
        if (wr_pend && wel)
            mem[addr[MEM_AW-1:0]] <= wr_byte;
        else if (fetch)
            mem_q <= mem[addr[MEM_AW-1:0]];
    end

endmodule

// File: tb/tb_spi_fram_responder.sv
// Directed bench for spi_fram_responder: table of SPI transactions plus
// hand-written reset and framing sequences.
module tb_spi_fram_responder;

    localparam int unsigned HALF = 8;

    logic clk = 1'b0;
    logic reset;
    logic spi_clk, spi_cs, spi_mosi;
    logic spi_miso, wel, active;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    spi_fram_responder #(.MEM_AW(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_clk  (spi_clk),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .wel      (wel),
        .active   (active)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {T_WREN, T_WRDI, T_RDSR, T_WRITE, T_READ, T_WEL} kind_t;
    typedef struct {
        kind_t           kind;
        logic [15:0]     addr;
        int unsigned     n;
        logic [2:0][7:0] d;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(kind_t k, logic [15:0] a, int unsigned n,
                                logic [7:0] d0, logic [7:0] d1, logic [7:0] d2);
        vec_t v;
        v.kind = k; v.addr = a; v.n = n;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int unsigned nb, output logic [7:0] rx);
        logic [7:0] sh;
        sh = tx;
        rx = '0;
        for (int unsigned i = 0; i < nb; i++) begin
            spi_mosi = sh[7];
            sh = {sh[6:0], 1'b0};
            wait_clk(HALF);
            rx = {rx[6:0], spi_miso};
            spi_clk = 1'b1;
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic cs_low;
        spi_cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic cs_high;
        wait_clk(HALF);
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] rx;
        case (v.kind)
            T_WREN, T_WRDI: begin
                cs_low();
                xfer((v.kind == T_WREN) ? 8'h06 : 8'h04, rx);
                cs_high();
            end
            T_RDSR: begin
                cs_low();
                xfer(8'h05, rx);
                for (int unsigned i = 0; i < v.n; i++) begin
                    xfer(8'h00, rx);
                    check($sformatf("v%0d rdsr[%0d]", idx, i), rx, v.d[i]);
                end
                cs_high();
            end
            T_WRITE, T_READ: begin
                cs_low();
                xfer((v.kind == T_READ) ? 8'h03 : 8'h02, rx);
                xfer(v.addr[15:8], rx);
                xfer(v.addr[7:0], rx);
                for (int unsigned i = 0; i < v.n; i++) begin
                    if (v.kind == T_READ) begin
                        xfer(8'h00, rx);
                        check($sformatf("v%0d read@%04h[%0d]", idx, v.addr, i), rx, v.d[i]);
                    end else begin
                        xfer(v.d[i], rx);
                    end
                end
                cs_high();
            end
            T_WEL: check($sformatf("v%0d wel", idx), {7'b0, wel}, v.d[0]);
            default: ;
        endcase
    endtask

    initial begin
        logic [7:0] rx;
        reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;

        vq.push_back(mk(T_RDSR,  16'h0000, 1, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WREN,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_RDSR,  16'h0000, 1, 8'h02, 8'h00, 8'h00));
        vq.push_back(mk(T_WEL,   16'h0000, 0, 8'h01, 8'h00, 8'h00));
        vq.push_back(mk(T_WRDI,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_RDSR,  16'h0000, 1, 8'h00, 8'h00, 8'h00));
        // preload known zeros
        vq.push_back(mk(T_WREN,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WRITE, 16'h0012, 1, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WREN,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WRITE, 16'h0020, 1, 8'h00, 8'h00, 8'h00));
        // burst write / read
        vq.push_back(mk(T_WREN,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WRITE, 16'h0010, 2, 8'hA5, 8'h5A, 8'h00));
        vq.push_back(mk(T_WEL,   16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_READ,  16'h0010, 3, 8'hA5, 8'h5A, 8'h00));
        // write without WREN is discarded
        vq.push_back(mk(T_WRITE, 16'h0020, 1, 8'h77, 8'h00, 8'h00));
        vq.push_back(mk(T_READ,  16'h0020, 1, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WEL,   16'h0000, 0, 8'h00, 8'h00, 8'h00));
        // aliasing and index wrap
        vq.push_back(mk(T_WREN,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_WRITE, 16'h03FF, 2, 8'h11, 8'h22, 8'h00));
        vq.push_back(mk(T_READ,  16'h0000, 1, 8'h22, 8'h00, 8'h00));
        vq.push_back(mk(T_READ,  16'h0400, 1, 8'h22, 8'h00, 8'h00));
        vq.push_back(mk(T_READ,  16'hFFFF, 2, 8'h11, 8'h22, 8'h00));
        // status repeats every byte
        vq.push_back(mk(T_WREN,  16'h0000, 0, 8'h00, 8'h00, 8'h00));
        vq.push_back(mk(T_RDSR,  16'h0000, 2, 8'h02, 8'h02, 8'h00));

        // reset state
        wait_clk(5);
        check("reset miso",   {7'b0, spi_miso}, 8'h00);
        check("reset wel",    {7'b0, wel},      8'h00);
        check("reset active", {7'b0, active},   8'h00);
        reset = 1'b0;
        wait_clk(10);
        check("idle active", {7'b0, active}, 8'h00);

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i], i);

        // WRDI followed by extra bits has no effect
        cs_low();
        xfer(8'h04, rx);
        xfer_bits(8'hE0, 3, rx);
        cs_high();
        check("wrdi+3 bits wel", {7'b0, wel}, 8'h01);

        // unknown opcode: miso stays low, wel unchanged
        cs_low();
        xfer(8'h9F, rx);
        xfer(8'h00, rx);
        check("ignore miso", rx, 8'h00);
        cs_high();
        check("unknown op wel", {7'b0, wel}, 8'h01);

        // reset in the middle of a WRITE data byte, cs held low
        cs_low();
        xfer(8'h02, rx);
        xfer(8'h00, rx);
        xfer(8'h10, rx);
        xfer_bits(8'hFF, 4, rx);
        wait_clk(4);
        reset = 1'b1;
        wait_clk(4);
        check("midreset active", {7'b0, active},   8'h00);
        check("midreset miso",   {7'b0, spi_miso}, 8'h00);
        check("midreset wel",    {7'b0, wel},      8'h00);
        reset = 1'b0;
        wait_clk(10);
        check("post-reset ignore", {7'b0, active}, 8'h01);
        xfer(8'h05, rx);
        check("post-reset miso", rx, 8'h00);
        check("post-reset hold", {7'b0, active}, 8'h01);
        cs_high();
        check("cs rise idle", {7'b0, active}, 8'h00);

        cs_low();
        xfer(8'h03, rx);
        xfer(8'h00, rx);
        xfer(8'h10, rx);
        xfer(8'h00, rx);
        check("after reset read0", rx, 8'hA5);
        xfer(8'h00, rx);
        check("after reset read1", rx, 8'h5A);
        cs_high();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_fram_responder.md
# spi_fram_responder

Synthesizable SPI target that emulates the serial FRAM the `fram_ram` master talks to over `spi_clk`/`spi_cs`/`spi_mosi`/`spi_miso`. It decodes the FRAM command set (WREN, WRDI, RDSR, READ, WRITE) with a 16-bit address phase and backs it with an on-chip byte array. It serves as the far end of the memory SPI link for on-chip self-test and for FPGA builds without an external FRAM part.

## Interface
- `MEM_AW`, 10: byte-array address width; array holds 2^MEM_AW bytes. SPI addresses alias modulo 2^MEM_AW.
- `clk`  in  1  system clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_clk`  in  1  SPI clock from the master, mode 0 (idle low).
- `spi_cs`  in  1  chip select, active low.
- `spi_mosi`  in  1  serial data from the master, MSB first.
- `spi_miso`  out  1  serial data to the master, MSB first; driven 0 when not shifting read data.
- `wel`  out  1  write-enable latch state.
- `active`  out  1  high while a selected transfer is being decoded (state ≠ IDLE).

## Operation
- `spi_clk`, `spi_cs` and `spi_mosi` each pass through a 2-flop synchronizer into `clk`. Rise/fall detection uses a third flop. All SPI decoding runs in `clk`; SPI pins are never used as clocks.
- Synchronized `spi_cs` rising: go to IDLE from any state, clear the bit counter, discard any partial byte, drive `spi_miso` to 0. Synchronized `spi_cs` falling: IDLE→CMD.
- Mode 0 timing: MOSI is sampled on a synchronized `spi_clk` rise. MISO is updated on a synchronized `spi_clk` fall. A 3-bit counter frames bytes.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, RD_DATA, WR_DATA, RDSR, IGNORE.
- CMD: when the 8th bit arrives, the opcode is decoded:
  - 0x06 WREN: go to IGNORE; set `wel` at the `spi_cs` rise.
  - 0x04 WRDI: go to IGNORE; clear `wel` at the `spi_cs` rise.
  - 0x05 RDSR: go to RDSR.
  - 0x03 READ: go to ADDR_HI.
  - 0x02 WRITE: go to ADDR_HI.
  - Any other opcode: go to IGNORE.
- WREN/WRDI take effect only if exactly 8 bits were clocked before `spi_cs` rose. Otherwise `wel` is unchanged.
- ADDR_HI → ADDR_LO → data state. The 16-bit address is assembled MSB first. The array index is `addr[MEM_AW-1:0]`.
- RD_DATA:
  - On the `spi_clk` fall that follows the last address bit's rise, load `mem[addr]` and drive bit 7 on `spi_miso`.
  - Each later fall shifts out the next bit.
  - After 8 bits, `addr` increments and the next byte loads on the same fall as its bit 7. Reads continue for as long as the master clocks.
- WR_DATA:
  - Each completed byte writes `mem[addr]`, then `addr` increments.
  - The write happens only if `wel` = 1. With `wel` = 0 the bytes are consumed and discarded.
  - A partial byte at the `spi_cs` rise is not written.
  - If a WRITE command had `wel` = 1, `wel` clears at the `spi_cs` rise that ends it.
- RDSR: shifts out {6'b0, `wel`, 1'b0}, repeating every 8 bits.
- IGNORE: MOSI is ignored, `spi_miso` = 0, and the state holds until the `spi_cs` rise.
- Address increment wraps: 16-bit 0xFFFF→0x0000. Array index wraps 2^MEM_AW−1→0.

## Timing
- Reset: `spi_miso` = 0, `wel` = 0, `active` = 0, state IDLE, counters 0. Array contents are not reset.
- If `spi_cs` is low when reset deasserts, the FSM enters IGNORE and stays there until `spi_cs` rises. A transfer interrupted by reset is never resumed.
- Input-to-action latency is 3 `clk` cycles: 2 for synchronization, 1 for edge detect.
  - `spi_miso` changes at most 4 `clk` cycles after the `spi_clk` falling pin edge.
  - This requires each `spi_clk` half period to be ≥ 6 `clk` cycles.
- Array write commits 1 `clk` after the 8th-bit rise is detected. Read data is registered. The array is single-port; read and write never occur in the same cycle.
- If a `spi_cs` rise and a `spi_clk` edge are detected in the same cycle, the `spi_cs` rise wins and the edge is dropped.

## Test plan
- Reset with `spi_cs` = 1 → `spi_miso` = 0, `wel` = 0, `active` = 0. Then RDSR (0x05) → master reads 0x00.
- WREN (0x06) then RDSR → 0x02. Then WRDI (0x04) then RDSR → 0x00.
- WREN, then WRITE 0x02 addr 0x0010 data 0xA5,0x5A, then READ 0x03 addr 0x0010 for 3 bytes → 0xA5, 0x5A, 0x00 (pre-written). `wel` reads 0 after the WRITE.
- WRITE 0x0020 ← 0x77 without a prior WREN, then READ 0x0020 → the previous value (0x00 from preload); `wel` stays 0.
- MEM_AW = 10: WREN, then WRITE addr 0x03FF data 0x11,0x22 → READ 0x0000 = 0x22 and READ 0x0400 = 0x22 (aliasing and wrap).
- Assert reset mid-WRITE after 4 data bits with `spi_cs` still low → no array change, `active` = 0 during reset, and IGNORE holds until `spi_cs` rises. The next full READ behaves normally.
